dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder: the slave end of the datapath's load/store interface (cs, wr, rd, address, write data).
- Accepts one word request at a time, holds it for a programmable number of wait states, then returns a one-cycle ready pulse with read data or an error flag.
- Sits between the CPU load/store port and a word-addressed storage array. It lets the datapath be run against multi-cycle memory.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored (power of two, >=4)
- WAIT_STATES, 2, idle cycles between acceptance and response (0..15)
- BASE_ADDR, 32'h0000_0000, byte address of word 0

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-low reset
- cs  input  1  chip select / request valid
- wr  input  1  write request (qualified by cs)
- rd  input  1  read request (qualified by cs)
- addr  input  32  byte address
- wdata  input  32  write data
- rdata  output  32  read data; valid when ready=1 and err=0
- ready  output  1  one-cycle response pulse
- err  output  1  error flag; valid with ready
- busy  output  1  high from acceptance until the ready cycle inclusive

Behaviour:
- Clock, reset and storage:
  - One clock (clk). Reset rst is asynchronous, active-low.
  - While rst=0: state=IDLE, rdata=0, ready=0, err=0, busy=0, wait counter=0.
  - Storage contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - When cs=1, latch addr, wdata, wr and rd, and set busy=1 at that edge.
  - Go to WAIT if WAIT_STATES>0, else go to RESP.
  - cs=0 in IDLE: no action.
- WAIT:
  - The counter loads WAIT_STATES-1 on acceptance and decrements each cycle.
  - Go to RESP when the counter is 0.
  - Inputs are ignored during WAIT. cs dropping does not abort the transaction.
- RESP:
  - ready=1 for exactly one cycle. busy stays 1 in this cycle.
  - Next state is IDLE. A new request can be accepted on the cycle after RESP, never on the RESP cycle itself.
- Latency:
  - Edges from the acceptance edge to ready high = WAIT_STATES+1.
  - WAIT_STATES=0 gives ready in the cycle following acceptance.
- Error decode, evaluated on the latched request:
  - Error conditions, any of:
    - latched wr=1 and rd=1
    - latched wr=0 and rd=0
    - addr[1:0]!=0 (misaligned)
    - (addr-BASE_ADDR)>>2 >= DEPTH_WORDS, or addr<BASE_ADDR
  - On error: ready=1, err=1, rdata=0, storage unmodified.
- Index and range arithmetic:
  - Word index = (addr-BASE_ADDR)>>2, 32-bit unsigned subtract.
  - No wrap-around: out-of-range is an error, never aliased.
- Write:
  - Storage is written at the clock edge that enters RESP.
  - rdata=0 during the response.
- Read:
  - rdata is driven from storage during RESP, then holds its last value until the next response.
  - The ready/err qualification is unchanged by holding.
  - Read-after-write to the same address, back-to-back, returns the new data.
- Reset mid-transaction: rst=0 abandons the transaction and no write commits. This holds even if reset asserts in the RESP-entry cycle; asynchronous reset takes priority.

Decomposition:
- Shared package dmem_pkg:
  - state encoding constants (IDLE=2'd0, WAIT=2'd1, RESP=2'd2)
  - word width 32
  - byte-offset width 2
- One sub-module, dmem_array: synchronous single-port word RAM, DEPTH_WORDS x 32, with write-enable and registered read port.
- The FSM, request latch, error decode and counter stay in dmem_responder.

Test Plan:
- WAIT_STATES=2. Write 32'hDEAD_BEEF to addr 0x10 (cs=1, wr=1, rd=0) -> ready pulses 3 edges after acceptance, err=0. A subsequent read of 0x10 returns rdata=32'hDEAD_BEEF with err=0.
- Read from addr 0x13 (misaligned) -> ready=1, err=1, rdata=0. Word at 0x10 unchanged.
- Read from addr 4*DEPTH_WORDS=0x400 -> err=1. The write-error variant also leaves the word at 0x0 unchanged.
- cs=1 with wr=1 and rd=1 -> err=1 response. Then cs=1 with wr=rd=0 -> err=1.
- Start a write of 32'h1234_5678 to 0x20, assert rst=0 during WAIT, release, then read 0x20 -> all outputs 0 while in reset. The read returns the pre-test value; the write did not commit.
- Request held high continuously (back-to-back reads of 0x10, 0x14) -> busy drops for exactly one IDLE cycle between the two responses. Both responses carry correct data.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// dmem_pkg : shared constants for the data-memory responder slice
// Revision : 1.0
// ============================================================================
package dmem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned OFFS_W = 2;
  localparam int unsigned CNT_W  = 4;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t WAIT = 2'd1;
  localparam state_t RESP = 2'd2;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// dmem_array : single-port DEPTH_WORDS x 32 word RAM, registered read port
// Revision   : 1.0
// ============================================================================
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : dmem_array
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder : load/store slave with programmable wait states and error decode
// Revision       : 1.0
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cs_i,
  input  logic              wr_i,
  input  logic              rd_i,
  input  logic [WORD_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o,
  output logic              ready_o,
  output logic              err_o,
  output logic              busy_o
);

  localparam int unsigned      IDX_W    = $clog2(DEPTH_WORDS);
  localparam bit               DIRECT   = (WAIT_STATES == 0);
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] addr_q, wdata_q, rdata_q;
  logic              wr_q, rd_q, err_q;

  logic [WORD_W-1:0] w_addr, w_wdata, w_off, w_idx, w_resp_data, w_ram_rdata;
  logic              w_wr, w_rd, w_err, w_accept, w_enter_resp, w_ram_we, w_ram_re;

  // With zero wait states the response is entered on the acceptance edge, so
  // the decode and RAM access must see the live request rather than the latch.
  always_comb begin
    w_accept = (state_q == IDLE) && cs_i;
    if (state_q == IDLE) begin
      w_addr  = addr_i;
      w_wdata = wdata_i;
      w_wr    = wr_i;
      w_rd    = rd_i;
    end else begin
      w_addr  = addr_q;
      w_wdata = wdata_q;
      w_wr    = wr_q;
      w_rd    = rd_q;
    end
    w_off = w_addr - BASE_ADDR;
    w_idx = w_off >> OFFS_W;
    w_err = (w_wr == w_rd)
          || (w_addr[OFFS_W-1:0] != '0)
          || (w_addr < BASE_ADDR)
          || (w_idx >= DEPTH_WORDS);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (cs_i) begin
          cnt_d   = CNT_LOAD;
          state_d = DIRECT ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Gating with rst_ni keeps a write from committing on an edge where reset is held.
  assign w_enter_resp = (state_d == RESP) && (state_q != RESP);
  assign w_ram_we     = w_enter_resp && w_wr && !w_err && rst_ni;
  assign w_ram_re     = w_enter_resp && !w_wr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (w_accept) begin
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        wr_q    <= wr_i;
        rd_q    <= rd_i;
      end
      if (w_enter_resp) begin
        err_q <= w_err;
      end
      if (state_q == RESP) begin
        rdata_q <= w_resp_data;
      end
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (w_ram_we),
    .re_i    (w_ram_re),
    .idx_i   (w_idx[IDX_W-1:0]),
    .wdata_i (w_wdata),
    .rdata_o (w_ram_rdata)
  );

  always_comb begin
    ready_o     = (state_q == RESP);
    err_o       = ready_o && err_q;
    busy_o      = (state_q != IDLE);
    w_resp_data = (err_q || wr_q) ? '0 : w_ram_rdata;
    rdata_o     = ready_o ? w_resp_data : rdata_q;
  end

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// tb_dmem_responder : scoreboard bench for dmem_responder
// Revision          : 1.0
// ============================================================================
module tb_dmem_responder;

  localparam int          DEPTH = 256;
  localparam int          WS    = 2;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs, wr, rd;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        ready, err, busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  exp_t        sb[$];
  logic [31:0] model [DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_STATES (WS),
    .BASE_ADDR   (32'h0000_0000)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .cs_i    (cs),
    .wr_i    (wr),
    .rd_i    (rd),
    .addr_i  (addr),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .ready_o (ready),
    .err_o   (err),
    .busy_o  (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t predict(input logic w, input logic r, input logic [31:0] a, input int acc);
    exp_t e;
    e.err  = (w == r) || (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
    e.data = '0;
    if (!e.err && !w) e.data = model[a[9:2]];
    e.acc  = acc;
    return e;
  endfunction

  // Response monitor: every ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && ready) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", 32'(ready), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_err", 32'(err), 32'(e.err));
        check("resp_rdata", rdata, e.data);
        check("resp_latency", 32'(cyc - e.acc), 32'(WS));
        check("resp_busy", 32'(busy), 32'd1);
      end
    end
  end

  task automatic issue(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input bit track);
    exp_t e;
    @(negedge clk);
    cs = 1'b1; wr = w; rd = r; addr = a; wdata = d;
    @(posedge clk); #1;
    e = predict(w, r, a, cyc);
    if (track) begin
      sb.push_back(e);
      if (w && !e.err) model[a[9:2]] = d;
    end
    cs = 1'b0; wr = 1'b0; rd = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic xfer(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    issue(w, r, a, d, 1'b1);
    wait_idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdata"}, rdata, 32'd0);
    check({tag, "_ready"}, 32'(ready), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bit   low_seen;
    rst_n = 1'b0; cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic write/read and read-data hold
    xfer(1, 0, 32'h0000_0000, 32'h0BAD_F00D);
    xfer(1, 0, 32'h0000_0010, 32'hDEAD_BEEF);
    xfer(0, 1, 32'h0000_0010, 32'h0);
    check("rdata_hold", rdata, 32'hDEAD_BEEF);
    check("ready_low_after", 32'(ready), 32'd0);

    // Misaligned accesses
    xfer(0, 1, 32'h0000_0013, 32'h0);
    xfer(1, 0, 32'h0000_0011, 32'h5555_5555);
    xfer(0, 1, 32'h0000_0010, 32'h0);

    // Range boundary: last word valid, first word past the end rejected
    xfer(1, 0, 32'h0000_03FC, 32'h600D_CAFE);
    xfer(0, 1, 32'h0000_03FC, 32'h0);
    xfer(0, 1, 32'h0000_0400, 32'h0);
    xfer(1, 0, 32'h0000_0400, 32'hFFFF_FFFF);
    xfer(1, 0, 32'h8000_0000, 32'hFFFF_FFFF);
    xfer(0, 1, 32'h0000_0000, 32'h0);

    // Illegal command encodings
    xfer(1, 1, 32'h0000_0010, 32'h1111_1111);
    xfer(0, 0, 32'h0000_0010, 32'h2222_2222);
    xfer(0, 1, 32'h0000_0010, 32'h0);

    // Reset during WAIT abandons the write
    xfer(1, 0, 32'h0000_0020, 32'hAAAA_5555);
    issue(1, 0, 32'h0000_0020, 32'h1234_5678, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    check_reset_outputs("midrst_hold");
    rst_n = 1'b1;
    xfer(0, 1, 32'h0000_0020, 32'h0);

    // Read-after-write back-to-back
    xfer(1, 0, 32'h0000_0030, 32'h0F0F_1234);
    xfer(0, 1, 32'h0000_0030, 32'h0);

    // Request held high: two reads with a single idle cycle between them
    xfer(1, 0, 32'h0000_0014, 32'hCAFE_F00D);
    @(negedge clk);
    cs = 1'b1; wr = 1'b0; rd = 1'b1; addr = 32'h0000_0010;
    @(posedge clk); #1;
    sb.push_back(predict(0, 1, 32'h0000_0010, cyc));
    addr = 32'h0000_0014;
    low_seen = 1'b0;
    for (int i = 0; i < 40 && !low_seen; i++) begin
      @(negedge clk);
      if (!busy) low_seen = 1'b1;
    end
    check("b2b_idle_seen", 32'(low_seen), 32'd1);
    e = predict(0, 1, 32'h0000_0014, cyc + 1);
    sb.push_back(e);
    @(posedge clk); #1;
    check("b2b_busy_relatch", 32'(busy), 32'd1);
    cs = 1'b0; rd = 1'b0;
    wait_idle();

    repeat (2) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_dmem_responder
`default_nettype wire
